// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the instruction cache and its refill controller.
package icache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_FILL   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_FLUSH  = 3'd4
  } state_t;

  function automatic int idx_width(input int num_blocks, input int n);
    return $clog2(num_blocks / n);
  endfunction

  function automatic int boff_width(input int words_per_block);
    return $clog2(words_per_block);
  endfunction

  function automatic int byte_width(input int word_size);
    return $clog2(word_size);
  endfunction

  function automatic int way_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int tag_width(input int addr_w, input int num_blocks, input int n,
                                   input int words_per_block, input int word_size);
    return addr_w - idx_width(num_blocks, n) - boff_width(words_per_block) - byte_width(word_size);
  endfunction

  // Extracts a field (tag, index or word offset) from a byte address, given its LSB and width.
  function automatic logic [63:0] addr_field(input logic [63:0] addr, input int lsb, input int width);
    return (addr >> lsb) & ((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/icache_refill_ctrl_rr.sv
// Per-set round-robin victim pointers: one read port, one advance port, and a clear-all.
module rr_victim_sel #(
  parameter int NUM_SETS = 4,
  parameter int N        = 4,
  parameter int IDX_W    = 2,
  parameter int WAY_W    = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [IDX_W-1:0] i_rd_set,
  output logic [WAY_W-1:0] o_rd_way,
  input  logic             i_adv_en,
  input  logic [IDX_W-1:0] i_adv_set,
  input  logic             i_clr
);

  logic [WAY_W-1:0] r_ptr [NUM_SETS];

  assign o_rd_way = r_ptr[i_rd_set];

  // Clear wins over advance; wrap is explicit so non-power-of-two N still works.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_SETS; i++) r_ptr[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < NUM_SETS; i++) r_ptr[i] <= '0;
    end else if (i_adv_en) begin
      r_ptr[i_adv_set] <= (r_ptr[i_adv_set] == WAY_W'(N - 1)) ? '0 : r_ptr[i_adv_set] + WAY_W'(1);
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache miss handler: requests the missing line, streams beats into the victim way,
// commits tag/valid once the whole line is in, and sequences full-cache flushes.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter  int ADDRESS_WIDTH   = 32,
  parameter  int N               = 4,
  parameter  int WORDS_PER_BLOCK = 4,
  parameter  int NUM_BLOCKS      = 16,
  parameter  int WORD_SIZE       = 4,
  localparam int NUM_SETS        = NUM_BLOCKS / N,
  localparam int IDX_W           = idx_width(NUM_BLOCKS, N),
  localparam int BOFF_W          = boff_width(WORDS_PER_BLOCK),
  localparam int BYTE_W          = byte_width(WORD_SIZE),
  localparam int TAG_W           = tag_width(ADDRESS_WIDTH, NUM_BLOCKS, N, WORDS_PER_BLOCK, WORD_SIZE),
  localparam int WAY_W           = way_width(N)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_fetch_valid,
  input  logic [ADDRESS_WIDTH-1:0] i_fetch_addr,
  input  logic                     i_cache_hit,
  input  logic                     i_flush_req,
  output logic                     o_stall,
  output logic                     o_mem_req_valid,
  input  logic                     i_mem_req_ready,
  output logic [ADDRESS_WIDTH-1:0] o_mem_req_addr,
  input  logic                     i_mem_resp_valid,
  input  logic [31:0]              i_mem_resp_data,
  output logic                     o_fill_we,
  output logic [IDX_W-1:0]         o_fill_set,
  output logic [WAY_W-1:0]         o_fill_way,
  output logic [BOFF_W-1:0]        o_fill_word,
  output logic [31:0]              o_fill_data,
  output logic                     o_commit,
  output logic [TAG_W-1:0]         o_commit_tag,
  output logic                     o_inv_we,
  output logic                     o_busy_flush,
  output logic [2:0]               o_state
);

  // Handshake: the line request transfers on a cycle where o_mem_req_valid && i_mem_req_ready;
  // valid and address hold steady until then. Response beats have no back-pressure.

  state_t             r_state, w_next;
  logic [TAG_W-1:0]   r_tag;
  logic [IDX_W-1:0]   r_idx;
  logic [BOFF_W-1:0]  r_beat;
  logic [IDX_W-1:0]   r_fset;
  logic               r_flush_pend;
  logic               w_miss, w_rr_adv, w_rr_clr;
  logic [WAY_W-1:0]   w_way;
  logic [TAG_W-1:0]   w_fetch_tag;
  logic [IDX_W-1:0]   w_fetch_idx;

  assign w_miss      = i_fetch_valid && !i_cache_hit;
  assign w_fetch_tag = TAG_W'(addr_field(64'(i_fetch_addr), IDX_W + BOFF_W + BYTE_W, TAG_W));
  assign w_fetch_idx = IDX_W'(addr_field(64'(i_fetch_addr), BOFF_W + BYTE_W, IDX_W));
  assign o_stall     = (r_state != ST_IDLE) || w_miss || i_flush_req;
  assign o_state     = r_state;

  rr_victim_sel #(
    .NUM_SETS (NUM_SETS),
    .N        (N),
    .IDX_W    (IDX_W),
    .WAY_W    (WAY_W)
  ) u_rr (
    .clk       (clk),
    .resetn    (resetn),
    .i_rd_set  (r_idx),
    .o_rd_way  (w_way),
    .i_adv_en  (w_rr_adv),
    .i_adv_set (r_idx),
    .i_clr     (w_rr_clr)
  );

  always_comb begin
    w_next          = r_state;
    o_mem_req_valid = 1'b0;
    o_mem_req_addr  = '0;
    o_fill_we       = 1'b0;
    o_fill_set      = '0;
    o_fill_way      = '0;
    o_fill_word     = '0;
    o_fill_data     = '0;
    o_commit        = 1'b0;
    o_commit_tag    = '0;
    o_inv_we        = 1'b0;
    o_busy_flush    = 1'b0;
    w_rr_adv        = 1'b0;
    w_rr_clr        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_miss)           w_next = ST_REQ;
        else if (i_flush_req) w_next = ST_FLUSH;
      end
      ST_REQ: begin
        o_mem_req_valid = 1'b1;
        o_mem_req_addr  = {r_tag, r_idx, {(BOFF_W + BYTE_W){1'b0}}};
        if (i_mem_req_ready) w_next = ST_FILL;
      end
      ST_FILL: begin
        o_fill_set = r_idx;
        o_fill_way = w_way;
        if (i_mem_resp_valid) begin
          o_fill_we   = 1'b1;
          o_fill_word = r_beat;
          o_fill_data = i_mem_resp_data;
          if (r_beat == BOFF_W'(WORDS_PER_BLOCK - 1)) w_next = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        o_commit     = 1'b1;
        o_commit_tag = r_tag;
        o_fill_set   = r_idx;
        o_fill_way   = w_way;
        w_rr_adv     = 1'b1;
        w_next       = (r_flush_pend || i_flush_req) ? ST_FLUSH : ST_IDLE;
      end
      ST_FLUSH: begin
        o_inv_we     = 1'b1;
        o_busy_flush = 1'b1;
        o_fill_set   = r_fset;
        if (r_fset == IDX_W'(NUM_SETS - 1)) begin
          w_rr_clr = 1'b1;
          w_next   = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_tag        <= '0;
      r_idx        <= '0;
      r_beat       <= '0;
      r_fset       <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_miss) begin
        r_tag <= w_fetch_tag;
        r_idx <= w_fetch_idx;
        if (i_flush_req) r_flush_pend <= 1'b1;
      end
      if (i_flush_req && (r_state == ST_REQ || r_state == ST_FILL || r_state == ST_COMMIT))
        r_flush_pend <= 1'b1;
      if (r_state == ST_REQ && i_mem_req_ready) r_beat <= '0;
      if (r_state == ST_FILL && i_mem_resp_valid) r_beat <= r_beat + BOFF_W'(1);
      if (r_state == ST_FLUSH) r_fset <= r_fset + IDX_W'(1);
      // Entering a flush consumes the pending request and restarts the set walk.
      if (w_next == ST_FLUSH && r_state != ST_FLUSH) begin
        r_flush_pend <= 1'b0;
        r_fset       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: table of miss refills plus flush/stray-beat/reset sequences.
module tb_icache_refill_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        cache_hit = 1'b0;
  logic        flush_req = 1'b0;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        fill_we;
  logic [1:0]  fill_set;
  logic [1:0]  fill_way;
  logic [1:0]  fill_word;
  logic [31:0] fill_data;
  logic        commit;
  logic [25:0] commit_tag;
  logic        inv_we;
  logic        busy_flush;
  logic [2:0]  state;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    int          ready_dly;
    int          gap;
    logic [31:0] exp_req;
    logic [1:0]  exp_set;
    logic [1:0]  exp_way;
    logic [25:0] exp_tag;
    logic [31:0] data_base;
  } vec_t;

  vec_t vecs[8];

  icache_refill_ctrl dut (
    .clk              (clk),
    .resetn           (resetn),
    .i_fetch_valid    (fetch_valid),
    .i_fetch_addr     (fetch_addr),
    .i_cache_hit      (cache_hit),
    .i_flush_req      (flush_req),
    .o_stall          (stall),
    .o_mem_req_valid  (mem_req_valid),
    .i_mem_req_ready  (mem_req_ready),
    .o_mem_req_addr   (mem_req_addr),
    .i_mem_resp_valid (mem_resp_valid),
    .i_mem_resp_data  (mem_resp_data),
    .o_fill_we        (fill_we),
    .o_fill_set       (fill_set),
    .o_fill_way       (fill_way),
    .o_fill_word      (fill_word),
    .o_fill_data      (fill_data),
    .o_commit         (commit),
    .o_commit_tag     (commit_tag),
    .o_inv_we         (inv_we),
    .o_busy_flush     (busy_flush),
    .o_state          (state)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall"}, 64'(stall), 0);
    chk({tag, "_req_valid"}, 64'(mem_req_valid), 0);
    chk({tag, "_req_addr"}, 64'(mem_req_addr), 0);
    chk({tag, "_fill_we"}, 64'(fill_we), 0);
    chk({tag, "_fill_set"}, 64'(fill_set), 0);
    chk({tag, "_fill_way"}, 64'(fill_way), 0);
    chk({tag, "_fill_word"}, 64'(fill_word), 0);
    chk({tag, "_fill_data"}, 64'(fill_data), 0);
    chk({tag, "_commit"}, 64'(commit), 0);
    chk({tag, "_commit_tag"}, 64'(commit_tag), 0);
    chk({tag, "_inv_we"}, 64'(inv_we), 0);
    chk({tag, "_busy_flush"}, 64'(busy_flush), 0);
    chk({tag, "_state"}, 64'(state), 0);
  endtask

  // Full miss/refill/commit; optionally pulses flush_req in the first gap before beat 1.
  task automatic refill(input vec_t v, input bit inject_flush);
    tick;
    fetch_valid = 1'b1; fetch_addr = v.addr; cache_hit = 1'b0;
    #1;
    chk("miss_stall", 64'(stall), 1);
    chk("miss_state_idle", 64'(state), 0);
    chk("miss_no_req_yet", 64'(mem_req_valid), 0);
    tick;
    fetch_valid = 1'b0; fetch_addr = 32'hFFFF_FFFF;
    for (int d = 0; d < v.ready_dly; d++) begin
      mem_req_ready = 1'b0;
      #1;
      chk("req_valid_wait", 64'(mem_req_valid), 1);
      chk("req_addr_wait", 64'(mem_req_addr), 64'(v.exp_req));
      tick;
    end
    mem_req_ready = 1'b1;
    #1;
    chk("req_valid", 64'(mem_req_valid), 1);
    chk("req_addr", 64'(mem_req_addr), 64'(v.exp_req));
    tick;
    mem_req_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < v.gap; g++) begin
        mem_resp_valid = 1'b0;
        flush_req = (inject_flush && b == 1 && g == 0);
        #1;
        chk("gap_no_fill", 64'(fill_we), 0);
        chk("gap_no_commit", 64'(commit), 0);
        tick;
        flush_req = 1'b0;
      end
      mem_resp_valid = 1'b1;
      mem_resp_data = v.data_base + 32'(b);
      exp_q.push_back(mem_resp_data);
      #1;
      chk("fill_we", 64'(fill_we), 1);
      chk("fill_word", 64'(fill_word), 64'(b));
      chk("fill_set", 64'(fill_set), 64'(v.exp_set));
      chk("fill_way", 64'(fill_way), 64'(v.exp_way));
      chk("fill_no_commit", 64'(commit), 0);
      if (fill_we && exp_q.size() > 0) chk("fill_data", 64'(fill_data), 64'(exp_q.pop_front()));
      tick;
    end
    mem_resp_valid = 1'b0;
    mem_resp_data = '0;
    #1;
    chk("commit", 64'(commit), 1);
    chk("commit_tag", 64'(commit_tag), 64'(v.exp_tag));
    chk("commit_set", 64'(fill_set), 64'(v.exp_set));
    chk("commit_way", 64'(fill_way), 64'(v.exp_way));
    chk("commit_stall", 64'(stall), 1);
    chk("commit_no_fill", 64'(fill_we), 0);
    tick;
  endtask

  task automatic check_flush;
    for (int s = 0; s < 4; s++) begin
      #1;
      chk("flush_inv_we", 64'(inv_we), 1);
      chk("flush_set", 64'(fill_set), 64'(s));
      chk("flush_busy", 64'(busy_flush), 1);
      chk("flush_stall", 64'(stall), 1);
      tick;
    end
    #1;
    chk("flush_done_inv", 64'(inv_we), 0);
    chk("flush_done_busy", 64'(busy_flush), 0);
    chk("flush_done_state", 64'(state), 0);
  endtask

  initial begin
    vecs[0] = '{32'h0000_1234, 0, 0, 32'h0000_1230, 2'd3, 2'd0, 26'h48,  32'hA0};
    vecs[1] = '{32'h0000_2030, 0, 0, 32'h0000_2030, 2'd3, 2'd1, 26'h80,  32'h10};
    vecs[2] = '{32'h0000_3034, 0, 1, 32'h0000_3030, 2'd3, 2'd2, 26'hC0,  32'h20};
    vecs[3] = '{32'h0000_4038, 1, 0, 32'h0000_4030, 2'd3, 2'd3, 26'h100, 32'h30};
    vecs[4] = '{32'h0000_503C, 0, 0, 32'h0000_5030, 2'd3, 2'd0, 26'h140, 32'h40};
    vecs[5] = '{32'h0000_0010, 0, 0, 32'h0000_0010, 2'd1, 2'd0, 26'h0,   32'h50};
    vecs[6] = '{32'h0000_6030, 2, 1, 32'h0000_6030, 2'd3, 2'd1, 26'h180, 32'h60};
    vecs[7] = '{32'h0000_7020, 5, 2, 32'h0000_7020, 2'd2, 2'd0, 26'h1C0, 32'h70};

    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    resetn = 1'b1;
    tick;
    #1;
    chk_zero("after_reset");

    for (int i = 0; i < 8; i++) begin
      refill(vecs[i], 1'b0);
      #1;
      chk("post_commit_state", 64'(state), 0);
      chk("post_commit_stall", 64'(stall), 0);
    end

    // Stray beats in IDLE must not write the array.
    for (int i = 0; i < 3; i++) begin
      tick;
      mem_resp_valid = 1'b1;
      mem_resp_data = 32'hDEAD_0000 + 32'(i);
      #1;
      chk("stray_no_fill", 64'(fill_we), 0);
      chk("stray_no_commit", 64'(commit), 0);
    end
    mem_resp_valid = 1'b0;

    // Flush from IDLE.
    tick;
    flush_req = 1'b1;
    #1;
    chk("idle_flush_stall", 64'(stall), 1);
    tick;
    flush_req = 1'b0;
    check_flush();

    // Flush during FILL on set 2 (rr[2]=0 after the idle flush cleared it).
    begin
      vec_t fv;
      fv = '{32'h0000_8024, 0, 1, 32'h0000_8020, 2'd2, 2'd0, 26'h200, 32'hC0};
      refill(fv, 1'b1);
      check_flush();
      fv = '{32'h0000_9030, 0, 0, 32'h0000_9030, 2'd3, 2'd0, 26'h240, 32'hD0};
      refill(fv, 1'b0);
      #1;
      chk("post_flush_refill_idle", 64'(state), 0);
    end

    // Reset asserted during the second beat of a refill.
    tick;
    fetch_valid = 1'b1; fetch_addr = 32'h0000_A034; cache_hit = 1'b0;
    tick;
    fetch_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'hB0;
    exp_q.push_back(32'hB0);
    #1;
    chk("rst_beat0_we", 64'(fill_we), 1);
    if (fill_we && exp_q.size() > 0) chk("rst_beat0_data", 64'(fill_data), 64'(exp_q.pop_front()));
    tick;
    mem_resp_data = 32'hB1;
    #1;
    resetn = 1'b0;
    #1;
    chk_zero("mid_refill_reset");
    mem_resp_valid = 1'b0;
    mem_resp_data = '0;
    tick;
    #1;
    chk("reset_held_no_commit", 64'(commit), 0);
    tick;
    resetn = 1'b1;
    begin
      vec_t rv;
      rv = '{32'h0000_A034, 0, 0, 32'h0000_A030, 2'd3, 2'd0, 26'h280, 32'hE0};
      refill(rv, 1'b0);
      #1;
      chk("post_reset_refill_idle", 64'(state), 0);
    end

    chk("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
